// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline definitions: skid-buffer state, payload types and stage-buffer struct widths.
package defs;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  typedef logic [31:0] data_t;
  typedef logic        enable_t;

  // Stage-buffer payloads; each stage buffer sets WIDTH to the matching *_W.
  typedef struct packed {
    data_t pc;
    data_t instr;
  } if_id_t;

  typedef struct packed {
    data_t   pc;
    data_t   rs1_val;
    data_t   rs2_val;
    logic [4:0] rd;
    enable_t wb_en;
  } id_ex_t;

  typedef struct packed {
    data_t   alu_res;
    data_t   st_data;
    logic [4:0] rd;
    enable_t mem_en;
    enable_t wb_en;
  } ex_mem_t;

  typedef struct packed {
    data_t   wb_data;
    logic [4:0] rd;
    enable_t wb_en;
  } mem_wb_t;

  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int ID_EX_W  = $bits(id_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_cnt <= '0;
    else if (clr)                     r_cnt <= '0;
    else if (inc && (r_cnt != '1))    r_cnt <= r_cnt + CNT_W'(1);
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage buffer: 2-entry skid (registered ready) or 1-entry pass stage,
// with flush, occupancy and a saturating backpressure counter.
module pipe_skid_reg
  import defs::*;
#(
  parameter int WIDTH = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ready_i,
  input  logic             flush_i,
  input  logic             cnt_clr_i,
  output logic [1:0]       occ_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  skid_state_t      r_state, w_nxt;
  logic [WIDTH-1:0] r_main, r_skid;
  logic             w_in_fire, w_out_fire;
  logic             w_ld_main, w_ld_skid, w_sel_skid;
  logic             w_stall;

  assign valid_o = (r_state != EMPTY);
  assign occ_o   = r_state;
  assign data_o  = r_main;

  if (SKID != 0) begin : g_skid
    assign ready_o = (r_state != TWO);
  end else begin : g_pass
    assign ready_o = ready_i | ~valid_o;
  end

  assign w_in_fire  = valid_i & ready_o;
  assign w_out_fire = valid_o & ready_i;

  always_comb begin
    w_nxt      = r_state;
    w_ld_main  = 1'b0;
    w_ld_skid  = 1'b0;
    w_sel_skid = 1'b0;
    case (r_state)
      EMPTY: if (w_in_fire) begin
        w_nxt     = ONE;
        w_ld_main = 1'b1;
      end
      ONE: begin
        if (w_in_fire) begin
          // Only the skid variant can accept while downstream is stalled.
          if ((SKID != 0) && !ready_i) begin
            w_nxt     = TWO;
            w_ld_skid = 1'b1;
          end else begin
            w_ld_main = 1'b1;
          end
        end else if (w_out_fire) begin
          w_nxt = EMPTY;
        end
      end
      TWO: if (w_out_fire) begin
        w_nxt      = ONE;
        w_ld_main  = 1'b1;
        w_sel_skid = 1'b1;
      end
      default: w_nxt = EMPTY;
    endcase
    if (flush_i) begin
      w_nxt     = EMPTY;
      w_ld_main = 1'b0;
      w_ld_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_nxt;
  end

  // Payload is never reset; it is only meaningful while the state says so.
  always_ff @(posedge clk) begin
    if (w_ld_main) r_main <= w_sel_skid ? r_skid : data_i;
    if (w_ld_skid) r_skid <= data_i;
  end

  assign w_stall = valid_o & ~ready_i;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall),
    .clr   (cnt_clr_i),
    .cnt_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, corner sequences and randomized
// traffic on a SKID=1 and a SKID=0 instance against a queue-based reference.
module tb_pipe_skid_reg;

  localparam int C1 = 4;
  localparam int C0 = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          v1, r1, f1, c1, v0, r0, f0, c0;
  logic [31:0]   d1, d0;
  logic          rdy1, vo1, rdy0, vo0;
  logic [31:0]   do1, do0;
  logic [1:0]    occ1, occ0;
  logic [C1-1:0] sc1;
  logic [C0-1:0] sc0;

  pipe_skid_reg #(.WIDTH(32), .SKID(1), .CNT_W(C1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .valid_i(v1), .data_i(d1), .ready_o(rdy1),
    .valid_o(vo1), .data_o(do1), .ready_i(r1), .flush_i(f1), .cnt_clr_i(c1),
    .occ_o(occ1), .stall_cnt_o(sc1));

  pipe_skid_reg #(.WIDTH(32), .SKID(0), .CNT_W(C0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .valid_i(v0), .data_i(d0), .ready_o(rdy0),
    .valid_o(vo0), .data_o(do0), .ready_i(r0), .flush_i(f0), .cnt_clr_i(c0),
    .occ_o(occ0), .stall_cnt_o(sc0));

  int n_chk = 0;
  int n_fail = 0;

  // Reference: a queue of held entries per instance, plus a stall counter.
  logic [31:0] q1[$], q0[$];
  int          m_c1, m_c0;
  int          n_in0, n_out0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    q1.delete(); q0.delete();
    m_c1 = 0; m_c0 = 0;
  endtask

  task automatic chk_post();
    chk("s1_valid", 32'(vo1), 32'(q1.size() > 0));
    chk("s1_occ",   32'(occ1), 32'(q1.size()));
    chk("s1_ready", 32'(rdy1), 32'(q1.size() < 2));
    chk("s1_cnt",   32'(sc1), 32'(m_c1));
    if (q1.size() > 0) chk("s1_data", do1, q1[0]);
    chk("s0_valid", 32'(vo0), 32'(q0.size() > 0));
    chk("s0_occ",   32'(occ0), 32'(q0.size()));
    chk("s0_cnt",   32'(sc0), 32'(m_c0));
    if (q0.size() > 0) chk("s0_data", do0, q0[0]);
  endtask

  // Inputs are set by the caller at the falling edge; one full clock follows.
  task automatic tick();
    bit in1, out1, in0, out0;
    #1;
    chk("s1_ready_pre", 32'(rdy1), 32'(q1.size() < 2));
    chk("s0_ready_pre", 32'(rdy0), 32'(r0 | (q0.size() == 0)));
    in1  = v1 && (q1.size() < 2);
    out1 = (q1.size() > 0) && r1;
    in0  = v0 && (r0 || (q0.size() == 0));
    out0 = (q0.size() > 0) && r0;
    @(posedge clk);
    if (c1) m_c1 = 0;
    else if (q1.size() > 0 && !r1 && m_c1 < (1 << C1) - 1) m_c1++;
    if (c0) m_c0 = 0;
    else if (q0.size() > 0 && !r0 && m_c0 < (1 << C0) - 1) m_c0++;
    if (f1) q1.delete();
    else begin
      if (out1) void'(q1.pop_front());
      if (in1)  q1.push_back(d1);
    end
    if (f0) q0.delete();
    else begin
      if (out0) begin void'(q0.pop_front()); n_out0++; end
      if (in0)  begin q0.push_back(d0); n_in0++; end
    end
    #1;
    chk_post();
    @(negedge clk);
  endtask

  typedef struct {
    logic        v, r, f, c;
    logic [31:0] d;
    logic        ev, er;
    logic [31:0] ed;
    logic [1:0]  eo;
    int          ec;
  } vec_t;

  function automatic vec_t mk(logic v, logic [31:0] d, logic r, logic f, logic c,
                              logic ev, logic [31:0] ed, logic er, logic [1:0] eo, int ec);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.f = f; t.c = c;
    t.ev = ev; t.ed = ed; t.er = er; t.eo = eo; t.ec = ec;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    v1 = 0; d1 = 0; r1 = 0; f1 = 0; c1 = 0;
    v0 = 0; d0 = 0; r0 = 0; f0 = 0; c0 = 0;
    n_in0 = 0; n_out0 = 0;
    model_reset();

    // Back-to-back throughput, ready_i high.
    for (int k = 1; k <= 8; k++) tbl.push_back(mk(1, 32'(k), 1, 0, 0, 1, 32'(k), 1, 2'd1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 2'd0, 0));
    // Skid fill, blocked third offer, then in-order drain.
    tbl.push_back(mk(1, 32'hA, 0, 0, 0, 1, 32'hA, 1, 2'd1, 0));
    tbl.push_back(mk(1, 32'hB, 0, 0, 0, 1, 32'hA, 0, 2'd2, 1));
    tbl.push_back(mk(1, 32'hD, 0, 0, 0, 1, 32'hA, 0, 2'd2, 2));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 32'hB, 1, 2'd1, 2));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 2'd0, 2));
    // Flush from full with an offer of 0xC.
    tbl.push_back(mk(1, 32'h11, 0, 0, 0, 1, 32'h11, 1, 2'd1, 2));
    tbl.push_back(mk(1, 32'h12, 0, 0, 0, 1, 32'h11, 0, 2'd2, 3));
    tbl.push_back(mk(1, 32'hC, 0, 1, 0, 0, 0, 1, 2'd0, 4));
    // Flush from ONE while an offer would be accepted: it must be dropped.
    tbl.push_back(mk(1, 32'h13, 0, 0, 0, 1, 32'h13, 1, 2'd1, 4));
    tbl.push_back(mk(1, 32'hC, 1, 1, 0, 0, 0, 1, 2'd0, 4));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 2'd0, 4));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 1, 2'd0, 0));

    #2 rst_n = 1'b0;
    #3;
    chk("rst_s1_valid", 32'(vo1), 0);
    chk("rst_s1_occ",   32'(occ1), 0);
    chk("rst_s1_ready", 32'(rdy1), 1);
    chk("rst_s1_cnt",   32'(sc1), 0);
    chk("rst_s0_valid", 32'(vo0), 0);
    chk("rst_s0_ready", 32'(rdy0), 1);
    chk("rst_s0_cnt",   32'(sc0), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      v1 = tbl[i].v; d1 = tbl[i].d; r1 = tbl[i].r; f1 = tbl[i].f; c1 = tbl[i].c;
      tick();
      chk($sformatf("tbl%0d_valid", i), 32'(vo1), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_ready", i), 32'(rdy1), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_occ", i),   32'(occ1), 32'(tbl[i].eo));
      chk($sformatf("tbl%0d_cnt", i),   32'(sc1), 32'(tbl[i].ec));
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), do1, tbl[i].ed);
    end
    f1 = 0; c1 = 0;

    // Saturation: 20 stalled cycles on a 4-bit counter, then clear during a stall.
    v1 = 1; d1 = 32'h55; r1 = 0; tick();
    v1 = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("sat_cnt", 32'(sc1), 32'((k < 15) ? k : 15));
    end
    c1 = 1; tick(); chk("sat_clr", 32'(sc1), 0);
    c1 = 0; tick(); chk("sat_after_clr", 32'(sc1), 1);
    r1 = 1; tick();

    // Asynchronous reset with two entries held, between clock edges.
    v1 = 1; d1 = 32'h77; r1 = 0; tick();
    d1 = 32'h78; tick();
    chk("pre_rst_occ", 32'(occ1), 2);
    v1 = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(vo1), 0);
    chk("arst_occ",   32'(occ1), 0);
    chk("arst_ready", 32'(rdy1), 1);
    chk("arst_cnt",   32'(sc1), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    r1 = 1; tick();

    // Randomized traffic on both instances; SKID=0 runs without flush for count tracking.
    n_in0 = 0; n_out0 = 0;
    for (int k = 0; k < 1000; k++) begin
      v1 = 1'($urandom_range(0, 1)); d1 = $urandom;
      r1 = ($urandom_range(0, 3) != 0); f1 = ($urandom_range(0, 15) == 0);
      c1 = ($urandom_range(0, 31) == 0);
      v0 = 1'($urandom_range(0, 1)); d0 = $urandom;
      r0 = 1'($urandom_range(0, 1)); c0 = ($urandom_range(0, 63) == 0);
      tick();
    end
    v1 = 0; v0 = 0; r1 = 1; r0 = 1; f1 = 0; c1 = 0; c0 = 0;
    repeat (3) tick();
    chk("s0_drained", 32'(q0.size()), 0);
    chk("s0_count", 32'(n_out0), 32'(n_in0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the payload width in bits (WIDTH >= 1).
REQ-002 The block SHALL have parameter SKID, default 1, meaning 1 selects a 2-entry skid stage with registered ready_o and 0 selects a 1-entry stage with combinational ready_o.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the stall-counter width in bits.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock, with all state updated on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-006 The block SHALL have port valid_i, input, 1 bit, meaning upstream offers data_i.
REQ-007 The block SHALL have port data_i, input, WIDTH bits, the upstream payload.
REQ-008 The block SHALL have port ready_o, output, 1 bit, meaning the block accepts data_i this cycle.
REQ-009 The block SHALL have port valid_o, output, 1 bit, meaning data_o is valid toward downstream.
REQ-010 The block SHALL have port data_o, output, WIDTH bits, the downstream payload.
REQ-011 The block SHALL have port ready_i, input, 1 bit, meaning downstream accepts data_o.
REQ-012 The block SHALL have port flush_i, input, 1 bit, meaning discard all held entries (branch or exception kill).
REQ-013 The block SHALL have port cnt_clr_i, input, 1 bit, a synchronous clear of the stall counter.
REQ-014 The block SHALL have port occ_o, output, 2 bits, the number of held entries (0..2).
REQ-015 The block SHALL have port stall_cnt_o, output, CNT_W bits, a saturating count of backpressure cycles.

Function
REQ-016 The block SHALL define in_fire = valid_i & ready_o and out_fire = valid_o & ready_i.
REQ-017 The block SHALL drive data_o from the main register only, so that it is never a combinational path from data_i.
REQ-018 For SKID=1, the block SHALL implement state EMPTY (occ 0), ONE (occ 1) and TWO (occ 2), with valid_o = (state != EMPTY) and ready_o = (state != TWO), both decoded from state flops only.
REQ-019 The state EMPTY SHALL move to ONE on in_fire, loading main <= data_i.
REQ-020 The state ONE SHALL behave as follows:
- in_fire & out_fire: stay in ONE, main <= data_i.
- in_fire & !ready_i: move to TWO, skid <= data_i.
- out_fire & !in_fire: move to EMPTY.
REQ-021 The state TWO SHALL move to ONE on out_fire, loading main <= skid; no input is accepted while in TWO.
REQ-022 For SKID=0, the block SHALL hold 1 entry, drive ready_o = ready_i | !valid_o combinationally, load main on in_fire, and clear valid on out_fire & !in_fire.
REQ-023 When flush_i = 1, the next state SHALL be EMPTY (occ 0) regardless of valid_i or ready_i, and the same-cycle in_fire SHALL be dropped.
REQ-024 While flush_i = 1, valid_o and ready_o SHALL keep their current-cycle values; the effect SHALL appear on the next cycle.
REQ-025 Payload registers SHALL load only on accept and SHALL never be cleared; only the valid/state flops SHALL be cleared.
REQ-026 The block SHALL never lose or duplicate an entry: every in_fire not killed by flush SHALL produce exactly one out_fire, in order.
REQ-027 stall_cnt_o SHALL increment by 1 in each cycle with valid_o & !ready_i, SHALL saturate at 2^CNT_W-1, and SHALL not wrap.
REQ-028 cnt_clr_i SHALL set stall_cnt_o to 0 and SHALL take priority over a same-cycle increment.
REQ-029 Latency SHALL be 1 cycle from in_fire to valid_o when the block is empty; sustained throughput SHALL be 1 entry per cycle with ready_i held at 1.

Reset
REQ-030 While rst_n = 0, the block SHALL asynchronously force state EMPTY, valid_o = 0, occ_o = 0 and stall_cnt_o = 0.
REQ-031 While rst_n = 0, ready_o SHALL be 1 for SKID=1, and SHALL equal 1 for SKID=0 (because valid_o = 0).
REQ-032 data_o and the skid payload SHALL not be reset and SHALL be don't-care while valid_o = 0.
REQ-033 Reset asserted mid-transfer SHALL discard all entries with no partial output; deassertion is synchronised externally.

Structure
REQ-034 The state enum (EMPTY, ONE, TWO) SHALL be placed as skid_state_t in the shared package defs, alongside data_t and enable_t.
REQ-035 The stall counter SHALL be a sub-module sat_counter (parameters CNT_W; inputs inc and clr) so that other pipeline buffers can reuse it.
REQ-036 Stage buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) SHALL instantiate pipe_skid_reg with WIDTH set to their packed struct width from defs.

Verification
REQ-037 Scenario, throughput: WIDTH=32, SKID=1, ready_i=1, send 0x1..0x8 back-to-back -> data_o = 0x1..0x8 on consecutive cycles, 1-cycle latency, occ_o never 2.
REQ-038 Scenario, skid fill: send 0xA, 0xB with ready_i=0 -> occ_o=2, ready_o=0 next cycle, stall_cnt_o increments; raise ready_i -> 0xA then 0xB appear in order.
REQ-039 Scenario, flush: with occ_o=2, pulse flush_i together with valid_i=1 carrying 0xC -> next cycle valid_o=0, occ_o=0, and 0xC is never output.
REQ-040 Scenario, saturation: CNT_W=4, hold valid_o=1 and ready_i=0 for 20 cycles -> stall_cnt_o=15 held; cnt_clr_i -> 0.
REQ-041 Scenario, async reset: with occ_o=2, assert rst_n=0 mid-cycle -> valid_o=0 and occ_o=0 immediately, before any clock edge.
REQ-042 Scenario, SKID=0 random ready_i over 1000 cycles -> scoreboard order and count match, and ready_o = ready_i | !valid_o every cycle.
